// File: rtl/rps_match_controller.sv
// Rock-paper-scissors match controller.
// Collects one move per player over valid/ready, holds the pair on the
// judge inputs for a single JUDGE cycle, then samples the judge result.
// It keeps the score and closes the match on the win target or the round limit.
// Every output is a flop. judge_p1/judge_p2 are the move latches themselves.
module rps_match_controller #(
  parameter int WINS_TO_MATCH = 3,
  parameter int MAX_ROUNDS    = 15,
  parameter int SCORE_W       = 4,
  parameter int ROUND_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               p1_valid,
  input  logic [1:0]         p1_move,
  output logic               p1_ready,
  input  logic               p2_valid,
  input  logic [1:0]         p2_move,
  output logic               p2_ready,
  output logic [1:0]         judge_p1,
  output logic [1:0]         judge_p2,
  input  logic [1:0]         judge_result,
  output logic               round_done,
  output logic [1:0]         round_result,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [ROUND_W-1:0] round_count,
  output logic               match_active,
  output logic               match_done,
  output logic [1:0]         match_winner
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_JUDGE   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam logic [1:0] MV_NONE = 2'b00;
  localparam logic [1:0] RES_P1  = 2'b01;
  localparam logic [1:0] RES_P2  = 2'b10;
  localparam logic [1:0] RES_TIE = 2'b11;

  localparam logic [SCORE_W-1:0] WIN_TGT = SCORE_W'(WINS_TO_MATCH);
  localparam logic [ROUND_W-1:0] RND_TGT = ROUND_W'(MAX_ROUNDS);

  state_e             state_q, state_d;
  logic               p1_ready_q, p1_ready_d;
  logic               p2_ready_q, p2_ready_d;
  logic [1:0]         judge_p1_q, judge_p1_d;
  logic [1:0]         judge_p2_q, judge_p2_d;
  logic               round_done_q, round_done_d;
  logic [1:0]         round_result_q, round_result_d;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d;
  logic [SCORE_W-1:0] p2_score_q, p2_score_d;
  logic [ROUND_W-1:0] round_count_q, round_count_d;
  logic               match_active_q, match_active_d;
  logic               match_done_q, match_done_d;
  logic [1:0]         match_winner_q, match_winner_d;

  logic               p1_acc, p2_acc;
  logic               match_over;

  // Next-state and next-output computation for the whole controller
  always_comb begin
    state_d        = state_q;
    judge_p1_d     = judge_p1_q;
    judge_p2_d     = judge_p2_q;
    round_done_d   = 1'b0;
    round_result_d = round_result_q;
    p1_score_d     = p1_score_q;
    p2_score_d     = p2_score_q;
    round_count_d  = round_count_q;
    match_winner_d = match_winner_q;
    p1_acc         = 1'b0;
    p2_acc         = 1'b0;
    match_over     = 1'b0;

    case (state_q)
      // A new match starts from a clean slate whether coming from IDLE or DONE
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d        = S_COLLECT;
          judge_p1_d     = MV_NONE;
          judge_p2_d     = MV_NONE;
          round_result_d = 2'b00;
          p1_score_d     = '0;
          p2_score_d     = '0;
          round_count_d  = '0;
          match_winner_d = 2'b00;
        end
      end

      S_COLLECT: begin
        // A "none" move is dropped and leaves ready high, so the player can retry
        p1_acc = p1_valid && p1_ready_q && (p1_move != MV_NONE);
        p2_acc = p2_valid && p2_ready_q && (p2_move != MV_NONE);
        if (p1_acc) judge_p1_d = p1_move;
        if (p2_acc) judge_p2_d = p2_move;
        // A held latch is never 00, so a nonzero latch marks that player as held
        if ((judge_p1_d != MV_NONE) && (judge_p2_d != MV_NONE))
          state_d = S_JUDGE;
      end

      S_JUDGE: begin
        // The judge has had the whole cycle to settle on the latched pair
        round_done_d   = 1'b1;
        round_result_d = judge_result;
        round_count_d  = round_count_q + ROUND_W'(1);
        if (judge_result == RES_P1) p1_score_d = p1_score_q + SCORE_W'(1);
        if (judge_result == RES_P2) p2_score_d = p2_score_q + SCORE_W'(1);
        judge_p1_d = MV_NONE;
        judge_p2_d = MV_NONE;

        match_over = (p1_score_d == WIN_TGT) || (p2_score_d == WIN_TGT) ||
                     (round_count_d == RND_TGT);
        if (match_over) begin
          state_d = S_DONE;
          // A player on the win target beats a plain score lead
          if (p1_score_d == WIN_TGT)        match_winner_d = RES_P1;
          else if (p2_score_d == WIN_TGT)   match_winner_d = RES_P2;
          else if (p1_score_d > p2_score_d) match_winner_d = RES_P1;
          else if (p2_score_d > p1_score_d) match_winner_d = RES_P2;
          else                              match_winner_d = RES_TIE;
        end else begin
          state_d = S_COLLECT;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs follow the state being entered, so they line up with it
    p1_ready_d     = (state_d == S_COLLECT) && (judge_p1_d == MV_NONE);
    p2_ready_d     = (state_d == S_COLLECT) && (judge_p2_d == MV_NONE);
    match_active_d = (state_d == S_COLLECT) || (state_d == S_JUDGE);
    match_done_d   = (state_d == S_DONE);
  end

  // State and registered outputs, with synchronous reset to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      p1_ready_q     <= 1'b0;
      p2_ready_q     <= 1'b0;
      judge_p1_q     <= MV_NONE;
      judge_p2_q     <= MV_NONE;
      round_done_q   <= 1'b0;
      round_result_q <= 2'b00;
      p1_score_q     <= '0;
      p2_score_q     <= '0;
      round_count_q  <= '0;
      match_active_q <= 1'b0;
      match_done_q   <= 1'b0;
      match_winner_q <= 2'b00;
    end else begin
      state_q        <= state_d;
      p1_ready_q     <= p1_ready_d;
      p2_ready_q     <= p2_ready_d;
      judge_p1_q     <= judge_p1_d;
      judge_p2_q     <= judge_p2_d;
      round_done_q   <= round_done_d;
      round_result_q <= round_result_d;
      p1_score_q     <= p1_score_d;
      p2_score_q     <= p2_score_d;
      round_count_q  <= round_count_d;
      match_active_q <= match_active_d;
      match_done_q   <= match_done_d;
      match_winner_q <= match_winner_d;
    end
  end

  assign p1_ready     = p1_ready_q;
  assign p2_ready     = p2_ready_q;
  assign judge_p1     = judge_p1_q;
  assign judge_p2     = judge_p2_q;
  assign round_done   = round_done_q;
  assign round_result = round_result_q;
  assign p1_score     = p1_score_q;
  assign p2_score     = p2_score_q;
  assign round_count  = round_count_q;
  assign match_active = match_active_q;
  assign match_done   = match_done_q;
  assign match_winner = match_winner_q;

endmodule
